// File: rtl/l2_rd_sched_pkg.sv
// Shared sizing, types and error-bit indices for the L2 read/write schedulers.
package l2_sched_pkg;
  localparam int NSTRMS = 16;
  localparam int SID_W  = $clog2(NSTRMS);
  localparam int L2_NCL = 128;
  localparam int PTR_W  = $clog2(L2_NCL);
  localparam int L1_NCL = 16;
  localparam int AV_W   = $clog2(L2_NCL + 1);
  localparam int CR_W   = $clog2(L1_NCL + 1);

  typedef logic [SID_W-1:0] sid_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [AV_W-1:0]  avail_t;
  typedef logic [CR_W-1:0]  credit_t;

  localparam int ERR_AVAIL_OVF  = 0;
  localparam int ERR_CREDIT_OVF = 1;
endpackage

// File: rtl/l2_rd_sched_if.sv
// L2 URAM read-address channel: valid/ready with stream id and line pointer.
interface l2_rd_sched_if;
  logic                o_l2_addr_v;
  logic                i_l2_addr_r;
  l2_sched_pkg::sid_t  o_l2_addr_sid;
  l2_sched_pkg::ptr_t  o_l2_addr_ptr;

  modport master (output o_l2_addr_v, output o_l2_addr_sid, output o_l2_addr_ptr,
                  input  i_l2_addr_r);
  modport slave  (input  o_l2_addr_v, input  o_l2_addr_sid, input  o_l2_addr_ptr,
                  output i_l2_addr_r);
endinterface

// File: rtl/l2_rd_sched_rr_arb.sv
// Round-robin arbiter: first requester after 'last', one-hot and encoded grant.
module rr_arb #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Walk from farthest to nearest so the nearest requester is written last.
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        idx = IW'((int'(last) + i) % N);
        vld = 1'b1;
      end
    end
    gnt = vld ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/l2_rd_sched.sv
// L2 read scheduler: per-stream avail/credit tracking, round-robin pick,
// one registered (sid, ptr) read request per cycle.
module l2_rd_sched
  import l2_sched_pkg::*;
(
  input  logic              clk1x,
  input  logic              reset,
  input  logic              i_cfg_v,
  input  sid_t              i_cfg_sid,
  input  ptr_t              i_cfg_ptr,
  input  logic [NSTRMS-1:0] i_avail_v,
  input  logic [NSTRMS-1:0] i_credit_v,
  l2_rd_sched_if.master     l2,
  output logic              o_idle,
  output logic [1:0]        o_err
);
  localparam avail_t  AV_MAX  = avail_t'(L2_NCL);
  localparam credit_t CR_FULL = credit_t'(L1_NCL);

  ptr_t    [NSTRMS-1:0] ptr_q;
  avail_t  [NSTRMS-1:0] avail_q;
  credit_t [NSTRMS-1:0] credit_q;
  sid_t                 rr_last;

  logic [NSTRMS-1:0] cfg_hit, has_work, elig, gnt, sel, av_ovf, cr_ovf;
  sid_t              gnt_idx;
  logic              gnt_vld, load, pick;

  always_comb begin
    cfg_hit = i_cfg_v ? (NSTRMS'(1) << i_cfg_sid) : '0;
    for (int s = 0; s < NSTRMS; s++)
      has_work[s] = (avail_q[s] != '0) && (credit_q[s] != '0);
    elig = has_work & ~cfg_hit;
  end

  rr_arb #(.N(NSTRMS), .IW(SID_W)) u_arb (
    .req  (elig),
    .last (rr_last),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .vld  (gnt_vld)
  );

  assign load   = !l2.o_l2_addr_v || l2.i_l2_addr_r;
  assign pick   = load && gnt_vld;
  assign sel    = pick ? gnt : '0;
  assign o_idle = !l2.o_l2_addr_v && !(|has_work);

  // A selection in the same cycle absorbs an increment, so no overflow then.
  always_comb begin
    for (int s = 0; s < NSTRMS; s++) begin
      av_ovf[s] = i_avail_v[s]  && !sel[s] && !cfg_hit[s] && (avail_q[s]  == AV_MAX);
      cr_ovf[s] = i_credit_v[s] && !sel[s] && !cfg_hit[s] && (credit_q[s] == CR_FULL);
    end
  end

  always_ff @(posedge clk1x) begin
    if (!reset) begin
      for (int s = 0; s < NSTRMS; s++) begin
        ptr_q[s]    <= '0;
        avail_q[s]  <= '0;
        credit_q[s] <= CR_FULL;
      end
    end else begin
      for (int s = 0; s < NSTRMS; s++) begin
        if (cfg_hit[s]) begin
          ptr_q[s]    <= i_cfg_ptr;
          avail_q[s]  <= '0;
          credit_q[s] <= CR_FULL;
        end else begin
          if (sel[s])
            ptr_q[s] <= ptr_q[s] + 1'b1;
          if (i_avail_v[s] && !sel[s] && !av_ovf[s])
            avail_q[s] <= avail_q[s] + 1'b1;
          else if (!i_avail_v[s] && sel[s])
            avail_q[s] <= avail_q[s] - 1'b1;
          if (i_credit_v[s] && !sel[s] && !cr_ovf[s])
            credit_q[s] <= credit_q[s] + 1'b1;
          else if (!i_credit_v[s] && sel[s])
            credit_q[s] <= credit_q[s] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk1x) begin
    if (!reset) begin
      l2.o_l2_addr_v   <= 1'b0;
      l2.o_l2_addr_sid <= '0;
      l2.o_l2_addr_ptr <= '0;
      rr_last          <= sid_t'(NSTRMS - 1);
      o_err            <= '0;
    end else begin
      if (load) begin
        l2.o_l2_addr_v <= gnt_vld;
        if (gnt_vld) begin
          l2.o_l2_addr_sid <= gnt_idx;
          l2.o_l2_addr_ptr <= ptr_q[gnt_idx];
          rr_last          <= gnt_idx;
        end
      end
      if (|av_ovf) o_err[ERR_AVAIL_OVF]  <= 1'b1;
      if (|cr_ovf) o_err[ERR_CREDIT_OVF] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l2_rd_sched.sv
// Scoreboard bench for l2_rd_sched: cycle model pushes expected requests,
// negedge monitor checks valid/idle/err and pops on every accepted request.
module tb_l2_rd_sched;
  import l2_sched_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_v = 1'b0;
  sid_t              cfg_sid = '0;
  ptr_t              cfg_ptr = '0;
  logic [NSTRMS-1:0] av = '0;
  logic [NSTRMS-1:0] cr = '0;
  logic              idle;
  logic [1:0]        err;

  l2_rd_sched_if l2();

  l2_rd_sched dut (
    .clk1x      (clk),
    .reset      (reset),
    .i_cfg_v    (cfg_v),
    .i_cfg_sid  (cfg_sid),
    .i_cfg_ptr  (cfg_ptr),
    .i_avail_v  (av),
    .i_credit_v (cr),
    .l2         (l2),
    .o_idle     (idle),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  typedef struct { int sid; int ptr; } exp_t;
  exp_t exp_q[$];
  int   acc_log[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: per-stream counts as plain integers, net arithmetic.
  int m_av[NSTRMS], m_cr[NSTRMS], m_ptr[NSTRMS];
  int m_last, m_err;
  bit m_v;

  always @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NSTRMS; s++) begin
        m_av[s] = 0; m_cr[s] = L1_NCL; m_ptr[s] = 0;
      end
      m_last = NSTRMS - 1; m_v = 0; m_err = 0;
      exp_q.delete();
    end else begin
      int pick;
      pick = -1;
      if (!m_v || l2.i_l2_addr_r) begin
        for (int k = 1; k <= NSTRMS; k++) begin
          int s;
          s = (m_last + k) % NSTRMS;
          if (pick < 0 && m_av[s] > 0 && m_cr[s] > 0 && !(cfg_v && int'(cfg_sid) == s))
            pick = s;
        end
        m_v = (pick >= 0);
        if (pick >= 0) begin
          exp_q.push_back('{sid: pick, ptr: m_ptr[pick]});
          m_last = pick;
        end
      end
      for (int s = 0; s < NSTRMS; s++) begin
        if (cfg_v && int'(cfg_sid) == s) begin
          m_ptr[s] = int'(cfg_ptr); m_av[s] = 0; m_cr[s] = L1_NCL;
        end else begin
          int d, a, c;
          d = (s == pick) ? 1 : 0;
          a = m_av[s] + int'(av[s]) - d;
          c = m_cr[s] + int'(cr[s]) - d;
          if (a > L2_NCL) begin a = L2_NCL; m_err = m_err | 1; end
          if (c > L1_NCL) begin c = L1_NCL; m_err = m_err | 2; end
          m_av[s] = a; m_cr[s] = c;
          if (d == 1) m_ptr[s] = (m_ptr[s] + 1) % L2_NCL;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit m_idle;
    m_idle = !m_v;
    for (int s = 0; s < NSTRMS; s++)
      if (m_av[s] > 0 && m_cr[s] > 0) m_idle = 0;
    chk("valid", l2.o_l2_addr_v, m_v);
    chk("idle", idle, m_idle);
    chk("err", err, m_err);
    if (reset && l2.o_l2_addr_v && l2.i_l2_addr_r) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("req_sid", l2.o_l2_addr_sid, e.sid);
        chk("req_ptr", l2.o_l2_addr_ptr, e.ptr);
      end
      acc_log.push_back(int'(l2.o_l2_addr_sid));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cfg_v = 1'b0; av = '0; cr = '0;
  endtask

  task automatic cfg(input int sid, input int ptr);
    cfg_v = 1'b1; cfg_sid = sid_t'(sid); cfg_ptr = ptr_t'(ptr);
    step();
  endtask

  function automatic int count_sid(input int sid);
    int n;
    n = 0;
    foreach (acc_log[i]) if (acc_log[i] == sid) n++;
    return n;
  endfunction

  initial begin
    l2.i_l2_addr_r = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_valid", l2.o_l2_addr_v, 0);

    // 1: three back-to-back requests from stream 1
    cfg(1, 0);
    l2.i_l2_addr_r = 1'b1;
    repeat (3) begin av[1] = 1'b1; step(); end
    repeat (4) step();
    chk("t1_idle", idle, 1);

    // 2: pointer wrap on stream 15
    cfg(15, 125);
    repeat (4) begin av[15] = 1'b1; step(); end
    repeat (6) step();

    // 3: round-robin order across streams 0, 3, 7
    acc_log.delete();
    l2.i_l2_addr_r = 1'b0;
    repeat (2) begin av = 16'h0089; step(); end
    l2.i_l2_addr_r = 1'b1;
    repeat (10) step();
    chk("t3_len", acc_log.size(), 6);
    if (acc_log.size() == 6) begin
      int order[6] = '{0, 3, 7, 0, 3, 7};
      for (int i = 0; i < 6; i++) chk("t3_order", acc_log[i], order[i]);
    end

    // 4: credit limit on stream 2
    acc_log.delete();
    cfg(2, 0);
    repeat (20) begin av[2] = 1'b1; step(); end
    repeat (10) step();
    chk("t4_cnt16", count_sid(2), 16);
    cr[2] = 1'b1; step();
    repeat (4) step();
    chk("t4_cnt17", count_sid(2), 17);

    // 5: backpressure hold of (4, 9)
    l2.i_l2_addr_r = 1'b0;
    cfg(4, 9);
    av[4] = 1'b1; step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) av[4] = 1'b1;
      step();
      chk("t5_hold_v", l2.o_l2_addr_v, 1);
      chk("t5_hold_sid", l2.o_l2_addr_sid, 4);
      chk("t5_hold_ptr", l2.o_l2_addr_ptr, 9);
    end
    l2.i_l2_addr_r = 1'b1;
    step();
    chk("t5_next_sid", l2.o_l2_addr_sid, 4);
    chk("t5_next_ptr", l2.o_l2_addr_ptr, 10);
    repeat (3) step();

    // 6: credit overflow, then reset during a held request
    cr[5] = 1'b1; step();
    chk("t6_err", err, 2);
    l2.i_l2_addr_r = 1'b0;
    av[5] = 1'b1; step();
    step();
    chk("t6_held", l2.o_l2_addr_v, 1);
    reset = 1'b0; step();
    reset = 1'b1;
    chk("t6_rst_v", l2.o_l2_addr_v, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_idle", idle, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      l2.i_l2_addr_r = ($urandom_range(0, 3) != 0);
      av = NSTRMS'($urandom & $urandom & $urandom);
      cr = NSTRMS'($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) begin
        cfg_v = 1'b1;
        cfg_sid = sid_t'($urandom_range(0, NSTRMS - 1));
        cfg_ptr = ptr_t'($urandom_range(0, L2_NCL - 1));
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b0;
      step();
      reset = 1'b1;
    end

    l2.i_l2_addr_r = 1'b1;
    repeat (300) step();
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_valid", l2.o_l2_addr_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_rd_sched.md
Name: l2_rd_sched

Overview:
- Read-request scheduler in front of the L2 URAM read port (`i_l2_addr_v/r/sid/ptr` of the URAM top).
- Tracks two counters per stream:
  - cache lines written into L2 (available);
  - free L1 line slots (credits).
- Round-robin arbitrates among streams that have at least one line available and at least one credit.
- Issues one (sid, ptr) read per cycle and advances each stream's circular L2 read pointer.

Parameters:
- NSTRMS, 16, streams served by this L2 channel
- SID_W, $clog2(NSTRMS), stream id width
- L2_NCL, 128, cache lines per stream in L2 (power of two)
- PTR_W, $clog2(L2_NCL), L2 line pointer width
- L1_NCL, 16, L1 line slots per stream (initial credit)
- AV_W, $clog2(L2_NCL+1), available-counter width
- CR_W, $clog2(L1_NCL+1), credit-counter width

Ports:
- clk1x  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- i_cfg_v  in  1  configure stream i_cfg_sid (one cycle pulse)
- i_cfg_sid  in  SID_W  stream being configured
- i_cfg_ptr  in  PTR_W  start read pointer for that stream
- i_avail_v  in  NSTRMS  bit s: one new line written to L2 for stream s
- i_credit_v  in  NSTRMS  bit s: one L1 slot of stream s freed
- o_l2_addr_v  out  1  read request valid
- i_l2_addr_r  in  1  read port ready
- o_l2_addr_sid  out  SID_W  stream id of request
- o_l2_addr_ptr  out  PTR_W  L2 line pointer of request
- o_idle  out  1  no request held, no stream eligible
- o_err  out  2  sticky; [0] avail overflow, [1] credit overflow

Behaviour:
- Reset (reset==0 at edge), same edge:
  - o_l2_addr_v=0, o_l2_addr_sid=0, o_l2_addr_ptr=0, o_err=0;
  - all ptr=0, avail=0, credit=L1_NCL;
  - rr_last=NSTRMS-1, so stream 0 has first priority.
- Reset asserted mid-transfer drops any held request with no handshake; reset wins over every other input.
- o_idle is combinational: !o_l2_addr_v && no eligible stream. It is 1 after reset.
- Eligibility: elig[s] = (avail[s]!=0) && (credit[s]!=0), evaluated on counter values at the start of the cycle.
- Output register:
  - load = !o_l2_addr_v || i_l2_addr_r.
  - When load and any elig: choose the first eligible s searching rr_last+1, rr_last+2, ... modulo NSTRMS.
  - On that choice: o_l2_addr_v<=1, sid<=s, ptr_out<=ptr[s], ptr[s]<=ptr[s]+1 (wraps at L2_NCL), avail[s]--, credit[s]--, rr_last<=s.
  - When load and nothing is eligible: o_l2_addr_v<=0.
  - When !load: sid and ptr are held stable; valid is never withdrawn.
- Counter commitment happens at selection, not at handshake. Throughput is one request per cycle with no bubble; latency from eligibility to o_l2_addr_v is 1 cycle.
- Same-cycle events on one stream, counters updated as net values:
  - avail increment plus selection: avail unchanged;
  - credit return plus selection: credit unchanged.
- Saturation:
  - i_avail_v[s] with avail[s]==L2_NCL and no selection of s: avail stays, o_err[0]<=1.
  - i_credit_v[s] with credit[s]==L1_NCL and no selection of s: credit stays, o_err[1]<=1.
  - o_err bits clear only on reset.
- Configuration (i_cfg_v) of stream c:
  - ptr[c]<=i_cfg_ptr, avail[c]<=0, credit[c]<=L1_NCL.
  - Overrides same-cycle avail, credit and selection effects on c.
  - c is excluded from selection that cycle.
  - A request for c already held in the output register stays valid until accepted.
- Pointer arithmetic is PTR_W-bit modulo, e.g. 127+1 -> 0.

Decomposition:
- Package l2_sched_pkg holds:
  - NSTRMS, L2_NCL, L1_NCL defaults and derived widths;
  - typedefs sid_t, ptr_t, avail_t, credit_t;
  - the o_err bit index constants ERR_AVAIL_OVF=0, ERR_CREDIT_OVF=1.
- Sub-module rr_arb (NSTRMS-wide round-robin with req vector, last-grant input, one-hot grant and encoded index, valid) is reused by the L2 write-channel arbiter.

Test Plan:
1. Reset, then cfg sid=1 ptr=0, 3 avail pulses on stream 1, i_l2_addr_r=1 -> three consecutive requests (1,0),(1,1),(1,2), no bubble; then o_l2_addr_v=0, o_idle=1.
2. cfg sid=15 ptr=125, 4 avail pulses, ready=1 -> ptrs 125,126,127,0 (wrap).
3. Streams 0, 3, 7 each with avail=2, ready=1 -> grant order 0,3,7,0,3,7.
4. Stream 2 with avail=20, credit=16 default, no credit returns -> exactly 16 requests then stall. One i_credit_v[2] pulse -> exactly one more request, 1 cycle later.
5. i_l2_addr_r=0 for 5 cycles with a request held (sid=4, ptr=9) -> v, sid, ptr stable. Ready raised -> accepted, next request issued the following cycle.
6. Credit pulse on stream 5 at credit=16 -> o_err=2'b10, counter stays 16. Reset (reset=0 one cycle) mid-stall with v=1 -> next cycle v=0, o_err=0, all counters at reset values.
